// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC, single-outstanding imem request, registered instruction to decode.
// Optional macro FETCH_PERF_CNT_EN adds the fetch_count accept counter output.
module instr_fetch_unit #(
    parameter int              PC_W     = 8,
    parameter int              INSTR_W  = 16,
    parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_valid,
    output logic [INSTR_W-1:0] instr,
    output logic [2:0]         opcode,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               jumpSelect,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_count
`endif
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
        S_HALT   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               halted_q, halted_d;
    logic               accept_s;
    logic [2:0]         opcode_s;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0]        cnt_q, cnt_d;
`endif

    assign accept_s = valid_q & instr_ready;
    assign opcode_s = instr_q[INSTR_W-1:INSTR_W-3];

    // Next-state logic for the fetch/decode/halt sequencer.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_d    = req_q;
        instr_d  = instr_q;
        valid_d  = valid_q;
        halted_d = halted_q;
`ifdef FETCH_PERF_CNT_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            S_FETCH: begin
                // The request rises one cycle after reset release, then waits for data.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (imem_valid) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_DECODE;
                end else begin
                    req_d = 1'b1;
                end
            end
            S_DECODE: begin
                if (accept_s) begin
                    valid_d = 1'b0;
`ifdef FETCH_PERF_CNT_EN
                    cnt_d   = cnt_q + 16'd1;
`endif
                    if (opcode_s == 3'b111) begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end else if (jumpSelect) begin
                        pc_d    = instr_q[PC_W-1:0];
                        req_d   = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        pc_d    = pc_q + PC_W'(1);
                        req_d   = 1'b1;
                        state_d = S_FETCH;
                    end
                end else begin
                    valid_d = 1'b1;
                end
            end
            S_HALT: begin
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b1;
            end
            default: begin
                state_d  = S_FETCH;
                req_d    = 1'b0;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            req_q    <= 1'b0;
            instr_q  <= {INSTR_W{1'b0}};
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
`ifdef FETCH_PERF_CNT_EN
            cnt_q    <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_q    <= req_d;
            instr_q  <= instr_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
`ifdef FETCH_PERF_CNT_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign opcode      = opcode_s;
    assign instr_valid = valid_q;
    assign halted      = halted_q;
`ifdef FETCH_PERF_CNT_EN
    assign fetch_count = cnt_q;
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of the opcode decoder (control_unit) in the single-issue CPU.
- Holds the program counter and issues single-outstanding requests to instruction memory.
- Registers the returned instruction word and presents it, with its 3-bit opcode field, to decode under a valid/ready handshake.
- Consumes the decoder's jumpSelect to redirect the PC; stops permanently on a HALT opcode.

Parameters:
- PC_W, 8, program counter / instruction address width.
- INSTR_W, 16, instruction word width; opcode = instr[INSTR_W-1:INSTR_W-3]; must satisfy INSTR_W >= PC_W+3.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req  output  1  fetch request, held until imem_valid.
- imem_addr  output  PC_W  fetch address, equals PC, stable while imem_req=1.
- imem_rdata  input  INSTR_W  instruction word, qualified by imem_valid.
- imem_valid  input  1  read data valid; ignored when imem_req=0.
- instr  output  INSTR_W  registered instruction to decode.
- opcode  output  3  instr[INSTR_W-1:INSTR_W-3], feeds control_unit.
- instr_valid  output  1  instr/opcode valid.
- instr_ready  input  1  decode accepts instr this cycle.
- jumpSelect  input  1  from control_unit; sampled only on the accept cycle.
- halted  output  1  HALT fetched and accepted; fetch stopped.

Behaviour:
- Reset (async assert): PC=RESET_PC, state=FETCH, imem_req=0, instr=0, instr_valid=0, halted=0.
- The first imem_req=1 occurs in the first clock after rst_n deasserts.
- States:
  - FETCH: imem_req=1, imem_addr=PC. On imem_valid=1, instr<=imem_rdata, instr_valid<=1, imem_req<=0 at that edge, then go to DECODE.
  - DECODE: instr_valid=1, imem_req=0. instr/opcode are held stable until accept (instr_valid & instr_ready). On accept:
    - opcode==3'b111: go to HALT.
    - jumpSelect=1: PC<=instr[PC_W-1:0], go to FETCH.
    - otherwise: PC<=PC+1, go to FETCH.
    - In all accept cases instr_valid<=0 at the same edge.
  - HALT: imem_req=0, instr_valid=0, halted=1. Only reset exits.
- Latency: instr_valid rises on the edge that samples imem_valid. For zero-wait memory (imem_valid in the first request cycle), req→valid is 1 cycle and back-to-back throughput is 1 instruction per 2 cycles.
- PC arithmetic is modulo 2^PC_W: PC=2^PC_W-1 increments to 0 with no flag.
- Jump target equal to the current PC is legal (tight loop).
- instr_ready while instr_valid=0 has no effect. jumpSelect outside the accept cycle has no effect.
- imem_valid outside FETCH is ignored; no data is latched.
- Opcodes 000 and 111 reach decode unchanged. Only 111 halts fetch, and only after it is accepted.
- Reset asserted mid-fetch or mid-decode: all state returns to reset values immediately. The in-flight request is abandoned.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds output port fetch_count [15:0], reset 0.
  - Increments by 1 on every accept cycle, including HALT and jumps; wraps 16'hFFFF→0.
  - Frozen in HALT.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0 → imem_req=0, instr_valid=0, halted=0. Release with RESET_PC=0 → next cycle imem_req=1, imem_addr=0.
- Sequential: zero-wait memory returns 16'h8000 (add) at addr 0, instr_ready=1 → instr_valid pulses, opcode=3'b100, next imem_addr=1.
- Wait states + backpressure: imem_valid delayed 3 cycles, then instr_ready low 4 cycles → imem_addr stays 0; instr held stable; no new request until accept.
- Jump: instr 16'h6025 (opcode 011) with jumpSelect=1 on accept → next imem_addr=8'h25; jumpSelect=1 on a non-accept cycle → no redirect.
- Wrap/halt: start PC=8'hFF with an add → next addr 8'h00. Fetch 16'hE000 and accept → halted=1, imem_req stays 0 for 20 cycles, imem_valid pulses ignored.
- FETCH_PERF_CNT_EN: after 5 accepts fetch_count=5. Assert rst_n=0 mid-fetch → fetch_count=0 and PC=RESET_PC immediately.
